// File: rtl/pipeline_ctrl_if.sv
// Stall/flush/redirect bundle between the 5-stage datapath and pipeline_ctrl.
// The master modport is the datapath; the slave modport is the sequencer.
interface pipeline_ctrl_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        excp_valid;
   logic [31:0] excp_handler_addr;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;

   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_handler_addr,
      input  stall, flush, new_pc
   );

   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_handler_addr,
      output stall, flush, new_pc
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline, with a stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall-cycle and flush-count performance counters.
module pipeline_ctrl #(
   parameter int STALL_TIMEOUT = 256,
   parameter int CNT_W         = 9
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.slave  pipe,
   input  logic            perf_clr,
   output logic            stall_timeout,
   output logic [31:0]     perf_stall_cycles,
   output logic [15:0]     perf_flush_count
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(STALL_TIMEOUT);

   state_t           state;
   state_t           state_next;
   logic             any_req;
   logic [5:0]       stall_dec;
   logic [5:0]       stall_o;
   logic             flush_o;
   logic [31:0]      new_pc_o;
   logic [31:0]      handler_q;
   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_cnt_next;

   // Deepest requesting stage wins: it freezes itself and every register upstream.
   always_comb begin
      any_req   = pipe.stallreq_id | pipe.stallreq_ex | pipe.stallreq_mem;
      stall_dec = 6'b000000;
      if (pipe.stallreq_mem)
         stall_dec = 6'b011111;
      else if (pipe.stallreq_ex)
         stall_dec = 6'b001111;
      else if (pipe.stallreq_id)
         stall_dec = 6'b000111;
   end

   always_comb begin
      state_next = state;
      stall_o    = 6'b000000;
      flush_o    = 1'b0;
      new_pc_o   = 32'h0;
      case (state)
         RUN: begin
            stall_o = stall_dec;
            if (pipe.excp_valid)
               state_next = FLUSH;
            else if (any_req)
               state_next = STALL;
         end
         STALL: begin
            stall_o = stall_dec;
            if (pipe.excp_valid)
               state_next = FLUSH;
            else if (!any_req)
               state_next = RUN;
         end
         FLUSH: begin
            flush_o    = 1'b1;
            new_pc_o   = handler_q;
            state_next = RUN;
         end
         default: state_next = RUN;
      endcase
      // Stall must read as zero the moment reset asserts, even with requests pending.
      if (!rst)
         stall_o = 6'b000000;
   end

   // Watchdog only counts edges spent inside STALL; any other destination clears it.
   always_comb begin
      wd_cnt_next = '0;
      if (state_next == STALL) begin
         wd_cnt_next = wd_cnt;
         if (state == STALL && wd_cnt != TIMEOUT_VAL)
            wd_cnt_next = wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         wd_cnt    <= '0;
         handler_q <= 32'h0;
      end else begin
         state  <= state_next;
         wd_cnt <= wd_cnt_next;
         if (state != FLUSH && pipe.excp_valid)
            handler_q <= pipe.excp_handler_addr;
      end
   end

   assign pipe.stall    = stall_o;
   assign pipe.flush    = flush_o;
   assign pipe.new_pc   = new_pc_o;
   assign stall_timeout = (wd_cnt == TIMEOUT_VAL);

`ifdef PIPE_CTRL_PERF_EN
   // A clear in the same cycle as a count event takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles <= 32'h0;
         perf_flush_count  <= 16'h0;
      end else if (perf_clr) begin
         perf_stall_cycles <= 32'h0;
         perf_flush_count  <= 16'h0;
      end else begin
         if (stall_o != 6'b000000)
            perf_stall_cycles <= perf_stall_cycles + 32'h1;
         if (flush_o)
            perf_flush_count <= perf_flush_count + 16'h1;
      end
   end
`else
   logic perf_clr_unused;
   assign perf_clr_unused   = perf_clr;
   assign perf_stall_cycles = 32'h0;
   assign perf_flush_count  = 16'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vectors, a behavioural model compared
// every cycle, and literal expectations for the headline scenarios.
module tb_pipeline_ctrl;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst;
   logic        perf_clr;
   logic        stall_timeout;
   logic [31:0] perf_stall_cycles;
   logic [15:0] perf_flush_count;

   int checks = 0;
   int errors = 0;

   pipeline_ctrl_if pif ();

   pipeline_ctrl #(.STALL_TIMEOUT(TIMEOUT), .CNT_W(3)) dut (
      .clk               (clk),
      .rst               (rst),
      .pipe              (pif),
      .perf_clr          (perf_clr),
      .stall_timeout     (stall_timeout),
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic id, input logic ex, input logic mem,
                                 input logic excp, input logic [31:0] addr, input logic clr);
      @(posedge clk);
      #1;
      pif.stallreq_id       = id;
      pif.stallreq_ex       = ex;
      pif.stallreq_mem      = mem;
      pif.excp_valid        = excp;
      pif.excp_handler_addr = addr;
      perf_clr              = clr;
   endtask

   // Model: a pending redirect, whether the previous edge left us stalled, and a
   // count of consecutive stalled edges capped at the timeout.
   bit          m_pend;
   logic [31:0] m_addr;
   bit          m_stalled;
   int          m_wd;
   logic [31:0] m_perf_stall;
   logic [15:0] m_perf_flush;

   function automatic logic [5:0] exp_stall();
      if (!rst || m_pend) return 6'h00;
      if (pif.stallreq_mem) return 6'h1F;
      if (pif.stallreq_ex)  return 6'h0F;
      if (pif.stallreq_id)  return 6'h07;
      return 6'h00;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pend = 0; m_addr = 32'h0; m_stalled = 0; m_wd = 0;
         m_perf_stall = 32'h0; m_perf_flush = 16'h0;
      end else begin
`ifdef PIPE_CTRL_PERF_EN
         if (perf_clr) begin
            m_perf_stall = 32'h0;
            m_perf_flush = 16'h0;
         end else begin
            if (exp_stall() != 6'h00) m_perf_stall = m_perf_stall + 32'h1;
            if (m_pend) m_perf_flush = m_perf_flush + 16'h1;
         end
`endif
         if (m_pend) begin
            m_pend = 0; m_stalled = 0; m_wd = 0;
         end else if (pif.excp_valid) begin
            m_pend = 1; m_addr = pif.excp_handler_addr; m_stalled = 0; m_wd = 0;
         end else if (pif.stallreq_id || pif.stallreq_ex || pif.stallreq_mem) begin
            if (m_stalled && m_wd < TIMEOUT) m_wd++;
            m_stalled = 1;
         end else begin
            m_stalled = 0; m_wd = 0;
         end
      end
   end

   always @(negedge clk) begin
      check_output("model_stall", 32'(pif.stall), 32'(exp_stall()));
      check_output("model_flush", 32'(pif.flush), 32'(rst && m_pend));
      check_output("model_new_pc", pif.new_pc, (rst && m_pend) ? m_addr : 32'h0);
      check_output("model_timeout", 32'(stall_timeout), 32'(rst && m_wd == TIMEOUT));
      check_output("model_perf_stall", perf_stall_cycles, m_perf_stall);
      check_output("model_perf_flush", 32'(perf_flush_count), 32'(m_perf_flush));
   end

   initial begin
      rst = 1'b0;
      perf_clr = 1'b0;
      pif.stallreq_id = 1'b1; pif.stallreq_ex = 1'b1; pif.stallreq_mem = 1'b1;
      pif.excp_valid = 1'b0; pif.excp_handler_addr = 32'h0;

      // Reset with every request raised, then release mid-cycle.
      repeat (2) @(posedge clk);
      #1;
      check_output("t1_reset_stall", 32'(pif.stall), 32'h00);
      check_output("t1_reset_flush", 32'(pif.flush), 32'h0);
      check_output("t1_reset_new_pc", pif.new_pc, 32'h0);
      check_output("t1_reset_timeout", 32'(stall_timeout), 32'h0);
      rst = 1'b1;
      #1;
      check_output("t1_release_stall", 32'(pif.stall), 32'h1F);
      apply_stimulus(0, 0, 0, 0, 32'h0, 1);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);

      // Single ID request for three cycles.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1, 0, 0, 0, 32'h0, 0);
         #1 check_output("t2_id_stall", 32'(pif.stall), 32'h07);
      end
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1 check_output("t2_released", 32'(pif.stall), 32'h00);

      // EX outranks ID; dropping EX is visible without waiting for an edge.
      apply_stimulus(1, 1, 0, 0, 32'h0, 0);
      #1 check_output("t3_id_ex", 32'(pif.stall), 32'h0F);
      pif.stallreq_ex = 1'b0;
      #1 check_output("t3_drop_ex", 32'(pif.stall), 32'h07);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);

      // Exception with a MEM stall; the flush cycle ignores new requests and exceptions.
      apply_stimulus(0, 0, 1, 1, 32'h40, 0);
      #1 check_output("t4_same_cycle_stall", 32'(pif.stall), 32'h1F);
      apply_stimulus(0, 0, 1, 1, 32'h80, 0);
      #1;
      check_output("t4_flush", 32'(pif.flush), 32'h1);
      check_output("t4_new_pc", pif.new_pc, 32'h40);
      check_output("t4_flush_stall", 32'(pif.stall), 32'h00);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1;
      check_output("t4_flush_done", 32'(pif.flush), 32'h0);
      check_output("t4_new_pc_zero", pif.new_pc, 32'h0);

      // Watchdog: asserts after four counting edges, saturates, clears on return to RUN.
      for (int i = 1; i <= 6; i++) begin
         apply_stimulus(0, 1, 0, 0, 32'h0, 0);
         #1 check_output("t5_timeout_rise", 32'(stall_timeout), 32'(i >= 6));
      end
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1 check_output("t5_saturated", 32'(stall_timeout), 32'h1);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1 check_output("t5_cleared", 32'(stall_timeout), 32'h0);

      // Exception taken from STALL after the watchdog has started counting.
      repeat (3) apply_stimulus(0, 1, 0, 0, 32'h0, 0);
      apply_stimulus(0, 1, 0, 1, 32'h0000_0180, 0);
      apply_stimulus(0, 1, 0, 0, 32'h0, 0);
      #1 check_output("stall_to_flush_pc", pif.new_pc, 32'h180);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);

      // Performance counters: five stall cycles and two flushes, then a clear.
      apply_stimulus(0, 0, 0, 0, 32'h0, 1);
      for (int i = 0; i < 5; i++) apply_stimulus(1, 0, 0, 0, 32'h0, 0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      apply_stimulus(0, 0, 0, 1, 32'h100, 0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      apply_stimulus(0, 0, 0, 1, 32'h200, 0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
`ifdef PIPE_CTRL_PERF_EN
      #1;
      check_output("t6_stall_cycles", perf_stall_cycles, 32'd5);
      check_output("t6_flush_count", 32'(perf_flush_count), 32'd2);
`else
      #1;
      check_output("t6_stall_cycles_off", perf_stall_cycles, 32'd0);
      check_output("t6_flush_count_off", 32'(perf_flush_count), 32'd0);
`endif
      apply_stimulus(1, 0, 0, 0, 32'h0, 1);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1;
      check_output("t6_clr_stall", perf_stall_cycles, 32'd0);
      check_output("t6_clr_flush", 32'(perf_flush_count), 32'd0);

      // Reset in the middle of a flush discards the redirect immediately.
      apply_stimulus(0, 0, 0, 1, 32'h300, 0);
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1 check_output("rst_pre_flush", 32'(pif.flush), 32'h1);
      rst = 1'b0;
      #1;
      check_output("rst_mid_flush", 32'(pif.flush), 32'h0);
      check_output("rst_mid_flush_pc", pif.new_pc, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      apply_stimulus(0, 0, 0, 0, 32'h0, 0);
      #1 check_output("rst_no_late_flush", 32'(pif.flush), 32'h0);
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL sim_timeout: got time %0t, expected completion before it", $time);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
